// File: rtl/fc_pkg.sv
// Shared types and helpers for the tiled fully-connected engine.
package fc_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_COMP,
        S_DRAIN,
        S_DONE
    } fc_state_e;

    // Scale an accumulator value (already sign-extended to 64 bits), optionally
    // clamp negatives to zero, then saturate to a signed out_w-bit range.
    function automatic logic signed [63:0] fc_scale(input logic signed [63:0] acc,
                                                    input int shift,
                                                    input int out_w,
                                                    input bit relu);
        logic signed [63:0] s;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        s  = acc >>> shift;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_w - 1));
        if (relu && s < 0) s = '0;
        if (s > hi)      s = hi;
        else if (s < lo) s = lo;
        return s;
    endfunction

endpackage

// File: rtl/fc_ifm_buffer.sv
// Single-port input-feature RAM: written while tile 0 streams in, read back
// (one-cycle latency, output held when not reading) for every later tile.
module fc_ifm_buffer
    import fc_pkg::*;
#(
    parameter int DEPTH = 9216,
    parameter int WIDTH = 8,
    parameter int AW    = 14
) (
    input  logic             clk,
    input  logic             we,
    input  logic             re,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port and registered read port share one address.
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        if (re) rdata <= mem[addr];
    end

endmodule

// File: rtl/fc_tiled_engine.sv
// Tiled FC engine: NUM_PE signed MAC lanes share one input-feature stream.
// Tile 0 streams features in (and records them), later tiles replay the buffer.
// Results leave one neuron per beat, lane 0 first.
// Build option: define FC_RELU_EN to clamp negative results to zero.
// ACC_WIDTH must not exceed 64 (output scaling is done in 64-bit arithmetic).
module fc_tiled_engine
    import fc_pkg::*;
#(
    parameter int NUM_PE    = 8,
    parameter int IFM_WIDTH = 8,
    parameter int WGT_WIDTH = 8,
    parameter int ACC_WIDTH = 32,
    parameter int OUT_WIDTH = 16,
    parameter int IFM_DEPTH = 9216,
    parameter int SHIFT     = 0
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic [$clog2(IFM_DEPTH+1)-1:0]  cfg_ifm_len,
    input  logic [15:0]                     cfg_num_tiles,
    output logic                            busy,
    output logic                            done,
    output logic                            cfg_err,
    input  logic                            ifm_valid,
    output logic                            ifm_ready,
    input  logic [IFM_WIDTH-1:0]            ifm,
    input  logic                            wgt_valid,
    output logic                            wgt_ready,
    input  logic [NUM_PE*WGT_WIDTH-1:0]     wgt,
    output logic                            ofm_valid,
    input  logic                            ofm_ready,
    output logic [OUT_WIDTH-1:0]            ofm
);

    localparam int LEN_W = $clog2(IFM_DEPTH + 1);
    localparam int AW    = (IFM_DEPTH > 1) ? $clog2(IFM_DEPTH) : 1;
    localparam int JW    = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
    localparam int PW    = IFM_WIDTH + WGT_WIDTH;
`ifdef FC_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    fc_state_e                        state;
    logic [LEN_W-1:0]                 len_q, k, rd_k;
    logic [15:0]                      tiles_q, tile_cnt;
    logic [JW-1:0]                    j;
    logic                             pf_valid;
    logic [IFM_WIDTH-1:0]             buf_rdata, mac_ifm;
    logic [AW-1:0]                    buf_addr;
    logic [NUM_PE-1:0][ACC_WIDTH-1:0] acc;
    logic                             load_fire, comp_fire, mac_fire, rd_en;
    logic                             last_k, last_j, ofm_fire;

    // In LOAD each port's ready mirrors the other's valid so a beat takes both.
    // In COMP the buffer output register doubles as the one-entry prefetch.
    assign ifm_ready = (state == S_LOAD) && wgt_valid;
    assign wgt_ready = (state == S_LOAD) ? ifm_valid : ((state == S_COMP) && pf_valid);
    assign load_fire = (state == S_LOAD) && ifm_valid && wgt_valid;
    assign comp_fire = (state == S_COMP) && pf_valid && wgt_valid;
    assign mac_fire  = load_fire || comp_fire;
    assign mac_ifm   = (state == S_LOAD) ? ifm : buf_rdata;
    assign last_k    = (k == len_q - LEN_W'(1));
    // Refill the prefetch whenever it is empty or being consumed this cycle.
    assign rd_en     = (state == S_COMP) && (rd_k < len_q) && (!pf_valid || comp_fire);
    assign buf_addr  = (state == S_LOAD) ? k[AW-1:0] : rd_k[AW-1:0];
    assign ofm_valid = (state == S_DRAIN);
    assign ofm_fire  = ofm_valid && ofm_ready;
    assign last_j    = (j == JW'(NUM_PE - 1));
    assign ofm       = ofm_valid
                     ? OUT_WIDTH'(fc_scale(64'($signed(acc[j])), SHIFT, OUT_WIDTH, RELU))
                     : '0;

    fc_ifm_buffer #(.DEPTH(IFM_DEPTH), .WIDTH(IFM_WIDTH), .AW(AW)) u_buf (
        .clk   (clk),
        .we    (load_fire),
        .re    (rd_en),
        .addr  (buf_addr),
        .wdata (ifm),
        .rdata (buf_rdata)
    );

    for (genvar p = 0; p < NUM_PE; p++) begin : g_mac
        logic signed [PW-1:0]        prod;
        logic signed [ACC_WIDTH-1:0] prod_x;
        logic [ACC_WIDTH-1:0]        acc_r;
        assign prod   = $signed(mac_ifm) * $signed(wgt[p*WGT_WIDTH +: WGT_WIDTH]);
        assign prod_x = ACC_WIDTH'(prod);
        assign acc[p] = acc_r;
        // Per-lane MAC; the first beat of each tile restarts the sum, wrapping on overflow.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)        acc_r <= '0;
            else if (mac_fire) acc_r <= ((k == '0) ? '0 : acc_r) + prod_x;
        end
    end

    // Control FSM: job setup, beat counting, output serialisation and completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            len_q    <= '0;
            tiles_q  <= '0;
            tile_cnt <= '0;
            k        <= '0;
            rd_k     <= '0;
            j        <= '0;
            pf_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            done    <= 1'b0;
            cfg_err <= 1'b0;
            if (mac_fire) k <= k + LEN_W'(1);
            if (rd_en) rd_k <= rd_k + LEN_W'(1);
            if (rd_en)          pf_valid <= 1'b1;
            else if (comp_fire) pf_valid <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    if (cfg_ifm_len == '0 || cfg_num_tiles == '0) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else if (cfg_ifm_len > LEN_W'(IFM_DEPTH)) begin
                        cfg_err <= 1'b1;
                    end else begin
                        state    <= S_LOAD;
                        busy     <= 1'b1;
                        len_q    <= cfg_ifm_len;
                        tiles_q  <= cfg_num_tiles;
                        tile_cnt <= '0;
                        k        <= '0;
                    end
                end
                S_LOAD, S_COMP: if (mac_fire && last_k) begin
                    state <= S_DRAIN;
                    j     <= '0;
                end
                S_DRAIN: if (ofm_fire) begin
                    j <= j + JW'(1);
                    if (last_j) begin
                        j <= '0;
                        if (tile_cnt + 16'd1 < tiles_q) begin
                            state    <= S_COMP;
                            tile_cnt <= tile_cnt + 16'd1;
                            k        <= '0;
                            rd_k     <= '0;
                            pf_valid <= 1'b0;
                        end else begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fc_tiled_engine.sv
// Scoreboard bench for fc_tiled_engine: jobs push expected outputs into a
// queue computed from plain dot products; a monitor pops on every ofm beat.
module tb_fc_tiled_engine;

    localparam int NUM_PE = 8;
    localparam int IW     = 8;
    localparam int WW     = 8;
    localparam int OW     = 16;
    localparam int DEPTH  = 9216;
    localparam int SHIFT  = 0;
    localparam int LW     = $clog2(DEPTH + 1);

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   start = 1'b0;
    logic [LW-1:0]          cfg_ifm_len = '0;
    logic [15:0]            cfg_num_tiles = '0;
    logic                   busy, done, cfg_err;
    logic                   ifm_valid = 1'b0;
    logic                   ifm_ready;
    logic [IW-1:0]          ifm = '0;
    logic                   wgt_valid = 1'b0;
    logic                   wgt_ready;
    logic [NUM_PE*WW-1:0]   wgt = '0;
    logic                   ofm_valid;
    logic                   ofm_ready = 1'b0;
    logic [OW-1:0]          ofm;

    fc_tiled_engine #(
        .NUM_PE(NUM_PE), .IFM_WIDTH(IW), .WGT_WIDTH(WW), .ACC_WIDTH(32),
        .OUT_WIDTH(OW), .IFM_DEPTH(DEPTH), .SHIFT(SHIFT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_ifm_len(cfg_ifm_len),
        .cfg_num_tiles(cfg_num_tiles), .busy(busy), .done(done), .cfg_err(cfg_err),
        .ifm_valid(ifm_valid), .ifm_ready(ifm_ready), .ifm(ifm),
        .wgt_valid(wgt_valid), .wgt_ready(wgt_ready), .wgt(wgt),
        .ofm_valid(ofm_valid), .ofm_ready(ofm_ready), .ofm(ofm)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0, cyc = 0;
    logic signed [OW-1:0]  exp_q[$];
    logic [IW-1:0]         ifm_arr[$];
    logic [NUM_PE*WW-1:0]  wgt_arr[$];
    bit stall = 0, hold_ready_low = 0, held = 0, ifm_done = 0, bad_ready = 0;
    logic [OW-1:0]         held_val;
    logic signed [OW-1:0]  mon_e;
    int ofm_beats = 0, done_cnt = 0, err_cnt = 0, last_fire_cyc = 0, done_cyc = 0;

    task automatic check(input string name, input longint act, input longint exp_v);
        n_chk++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
        end
    endtask

    // Reference: 32-bit wrapping sum, shift, optional clamp, 16-bit saturation.
    function automatic logic signed [OW-1:0] fmodel(input longint sum);
        int     a;
        longint s, hi, lo;
        a  = int'(sum);
        s  = longint'(a) >>> SHIFT;
        hi = (longint'(1) << (OW - 1)) - 1;
        lo = -(longint'(1) << (OW - 1));
`ifdef FC_RELU_EN
        if (s < 0) s = 0;
`endif
        if (s > hi) s = hi;
        if (s < lo) s = lo;
        return OW'(s);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    initial forever begin
        @(posedge clk); #1;
        ofm_ready = hold_ready_low ? 1'b0 : (stall ? 1'($urandom_range(0, 1)) : 1'b1);
    end

    // Monitor: pop/compare on each accepted beat, watch stability, done and errors.
    always @(negedge clk) begin
        if (!rst_n) begin
            held = 0;
        end else begin
            if (ofm_valid) begin
                if (held) check("ofm_stable", $signed(ofm), $signed(held_val));
                if (ofm_ready) begin
                    if (exp_q.size() == 0) check("ofm_unexpected", 1, 0);
                    else begin
                        mon_e = exp_q.pop_front();
                        check("ofm", $signed(ofm), mon_e);
                    end
                    ofm_beats++;
                    last_fire_cyc = cyc;
                    held = 0;
                end else begin
                    held = 1;
                    held_val = ofm;
                end
            end else held = 0;
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (cfg_err) err_cnt++;
            if (ifm_done && busy && ifm_ready) bad_ready = 1;
        end
    end

    task automatic gen_data(input int len, input int tiles, input int kind);
        logic [NUM_PE*WW-1:0] v;
        logic [IW-1:0]        x;
        ifm_arr.delete();
        wgt_arr.delete();
        for (int k = 0; k < len; k++) begin
            case (kind)
                1:       x = IW'(k + 1);
                2:       x = 8'd127;
                3:       x = 8'h80;
                default: x = IW'($urandom);
            endcase
            ifm_arr.push_back(x);
        end
        for (int i = 0; i < len * tiles; i++) begin
            for (int p = 0; p < NUM_PE; p++)
                v[p*WW +: WW] = (kind == 0) ? WW'($urandom) : (kind == 1) ? WW'(p + 1) : 8'd127;
            wgt_arr.push_back(v);
        end
    endtask

    task automatic build_expected(input int len, input int tiles);
        longint sum;
        logic signed [IW-1:0] a8;
        logic signed [WW-1:0] b8;
        logic [NUM_PE*WW-1:0] w;
        for (int t = 0; t < tiles; t++)
            for (int p = 0; p < NUM_PE; p++) begin
                sum = 0;
                for (int k = 0; k < len; k++) begin
                    a8 = ifm_arr[k];
                    w  = wgt_arr[t*len + k];
                    b8 = w[p*WW +: WW];
                    sum += longint'(a8) * longint'(b8);
                end
                exp_q.push_back(fmodel(sum));
            end
    endtask

    task automatic pulse_start(input int len, input int tiles);
        @(posedge clk); #1;
        start = 1'b1; cfg_ifm_len = LW'(len); cfg_num_tiles = 16'(tiles);
        @(posedge clk); #1;
        start = 1'b0; cfg_ifm_len = LW'($urandom); cfg_num_tiles = 16'($urandom);
    endtask

    task automatic drive_ifm(input int n);
        int i = 0, g = 0;
        while (i < n && g < n * 20 + 1000) begin
            @(posedge clk); #1;
            ifm_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            ifm = ifm_arr[i];
            @(negedge clk);
            if (ifm_valid && ifm_ready) i++;
            g++;
        end
        if (i < n) check("ifm_timeout", i, n);
        @(posedge clk); #1;
        ifm_valid = 1'b0;
    endtask

    task automatic drive_wgt(input int n);
        int i = 0, g = 0;
        while (i < n && g < n * 20 + 1000) begin
            @(posedge clk); #1;
            wgt_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            wgt = wgt_arr[i];
            @(negedge clk);
            if (wgt_valid && wgt_ready) i++;
            g++;
        end
        if (i < n) check("wgt_timeout", i, n);
        @(posedge clk); #1;
        wgt_valid = 1'b0;
    endtask

    task automatic run_job(input int len, input int tiles, input int kind,
                           input bit stl, input bit poke_start);
        int g = 0;
        stall = stl;
        gen_data(len, tiles, kind);
        build_expected(len, tiles);
        done_cnt = 0; err_cnt = 0; ofm_beats = 0; ifm_done = 0; bad_ready = 0;
        pulse_start(len, tiles);
        fork
            begin drive_ifm(len); ifm_done = 1; end
            drive_wgt(len * tiles);
            begin
                if (poke_start) begin
                    repeat (3) @(posedge clk);
                    #1 start = 1'b1; cfg_ifm_len = '0; cfg_num_tiles = 16'd1;
                    @(posedge clk);
                    #1 start = 1'b0;
                end
            end
        join
        while (done_cnt == 0 && g < 20000) begin @(posedge clk); g++; end
        repeat (3) @(posedge clk);
        check("done_count", done_cnt, 1);
        check("done_after_last_beat", done_cyc - last_fire_cyc, 1);
        check("ofm_beats", ofm_beats, tiles * NUM_PE);
        check("expected_left", exp_q.size(), 0);
        check("ifm_ready_in_replay", bad_ready, 0);
        check("busy_after_done", busy, 0);
        check("no_cfg_err", err_cnt, 0);
        ifm_done = 0;
        stall = 0;
        exp_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_cfg_err"}, cfg_err, 0);
        check({tag, "_ofm_valid"}, ofm_valid, 0);
        check({tag, "_ifm_ready"}, ifm_ready, 0);
        check({tag, "_wgt_ready"}, wgt_ready, 0);
        check({tag, "_ofm"}, ofm, 0);
    endtask

    initial begin
        int g;
        ifm_valid = 1'b1; wgt_valid = 1'b1;
        #12 check_reset_outputs("reset");
        ifm_valid = 1'b0; wgt_valid = 1'b0;
        @(negedge clk) rst_n = 1'b1;

        run_job(4, 1, 1, 0, 0);          // ofm = 10*(p+1)
        run_job(3, 3, 0, 0, 0);          // tiles 1,2 replay the buffer
        run_job(4, 1, 2, 0, 0);          // positive saturation
        run_job(4, 1, 3, 0, 0);          // negative saturation / relu clamp
        run_job(5, 3, 0, 1, 0);          // random stalls
        run_job(6, 2, 0, 1, 1);          // start while busy is ignored
        for (int r = 0; r < 4; r++)
            run_job($urandom_range(1, 12), $urandom_range(1, 4), 0, 1'(r), 0);

        // len == 0 and tiles == 0 finish immediately with no beats
        done_cnt = 0; ofm_beats = 0;
        pulse_start(0, 2);
        @(negedge clk);
        check("zero_len_done", done, 1);
        check("zero_len_busy", busy, 0);
        pulse_start(3, 0);
        @(negedge clk);
        check("zero_tiles_done", done, 1);
        repeat (3) @(posedge clk);
        check("zero_done_count", done_cnt, 2);
        check("zero_beats", ofm_beats, 0);

        // over-length request is rejected
        done_cnt = 0; err_cnt = 0;
        pulse_start(DEPTH + 1, 1);
        @(negedge clk);
        check("cfg_err_pulse", cfg_err, 1);
        check("cfg_err_busy", busy, 0);
        repeat (3) @(posedge clk);
        check("cfg_err_count", err_cnt, 1);
        check("cfg_err_no_done", done_cnt, 0);
        check("cfg_err_busy_later", busy, 0);

        // full-depth job is accepted
        run_job(DEPTH, 2, 0, 0, 0);

        // reset while outputs are pending
        hold_ready_low = 1;
        gen_data(3, 1, 0);
        pulse_start(3, 1);
        fork drive_ifm(3); drive_wgt(3); join
        g = 0;
        while (!ofm_valid && g < 100) begin @(negedge clk); g++; end
        check("drain_reached", ofm_valid, 1);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midreset");
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        hold_ready_low = 0;
        run_job(7, 2, 0, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_chk);
        $fatal(1, "watchdog");
    end

endmodule
